// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit using one 4-bit carry-lookahead slice, LSB nibble first.
// Optional build macro NSA_SAT_EN: saturate sum on signed overflow.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NN = WIDTH / 4;
  localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NN - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shadow_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  // Carry-lookahead slice on the current nibble
  logic [3:0] na, nb, g, p, ns;
  logic [4:0] c;

  always_comb begin
    na   = a_q[idx_q*4 +: 4];
    nb   = b_q[idx_q*4 +: 4];
    g    = na & nb;
    p    = na ^ nb;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & c[0]);
    ns   = p ^ c[3:0];
  end

  // Final-nibble commit values; only meaningful when idx_q == LastIdx
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] fin_sum;
  logic             ovf_c;

  always_comb begin
    raw_sum = {ns, shadow_q[WIDTH-5:0]};
    ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ns[3] != a_q[WIDTH-1]);
    fin_sum = raw_sum;
`ifdef NSA_SAT_EN
    if (ovf_c) begin
      fin_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    fin_sum = raw_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          shadow_q[idx_q*4 +: 4] <= ns;
          carry_q                <= c[4];
          if (idx_q == LastIdx) begin
            sum     <= fin_sum;
            cout    <= c[4];
            ovf     <= ovf_c;
            zero    <= (fin_sum == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            idx_q   <= '0;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_exp = 16'h0000;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts edges until done; cyc_in is edges already spent since acceptance
  task automatic wait_done(input string tag, input int cyc_in);
    int cyc;
    cyc = cyc_in;
    while (done !== 1'b1 && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 4);
  endtask

  task automatic check_result(input string tag, input logic [15:0] es, input logic ec,
                              input logic eo, input logic ez);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_zero"}, zero, ez);
    last_exp = es;
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
    a = ia;
    b = ib;
    sub = isub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_held"}, sum, last_exp);
    wait_done(tag, 0);
    check_result(tag, es, ec, eo, ez);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_zero", zero, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("done_pulse", done, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("zsub", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef NSA_SAT_EN
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("novf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("novf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

    // start pulsed while busy must be ignored
    a = 16'h0001;
    b = 16'h0002;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h5555;
    b = 16'h1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 1);
    check_result("ignore", 16'h0003, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("noqueue_busy", busy, 1'b0);

    // start held high: each done 4 edges after its own acceptance
    a = 16'h0010;
    b = 16'h0020;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("held1", 0);
    check_result("held1", 16'h0030, 1'b0, 1'b0, 1'b0);
    a = 16'h0100;
    b = 16'h0200;
    @(posedge clk);
    #1;
    check("held2_busy", busy, 1'b1);
    wait_done("held2", 0);
    check_result("held2", 16'h0300, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    @(posedge clk);
    #1;

    // reset two clocks into an operation
    a = 16'h4444;
    b = 16'h1111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, 16'h0000);
    check("abort_done", done, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort_nodone", done, 1'b0);
    end
    rst_n = 1'b1;
    last_exp = 16'h0000;
    @(posedge clk);
    #1;
    run_op("post_rst", 16'h0100, 16'h0022, 1'b0, 16'h0122, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
